gr_writeback_scheduler: RTL and testbench
=========================================

Name: gr_writeback_scheduler

Overview:
- Shares the two write ports of the 16x32 general register file among NUM_REQ writeback requesters (ALU, load unit, special-register moves, and so on).
- Grants up to two requests per cycle using round-robin. Two writes to the same register are never granted in the same cycle.
- Grants are staged through one register stage, then driven onto the file's write ports 1 and 2.
- Exports a per-register busy vector, which the issue stage uses for interlock.

Parameters:
- NUM_REQ, 4: number of writeback requesters; must be at least 2.
- ADDR_W, 4: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed target register addresses; requester i uses slice i
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses slice i
- req_ready  out  NUM_REQ  per-requester grant (accept)
- hold  in  1  when 1, suppresses all grants this cycle
- we1  out  1  write enable, register file port 1
- waddr1  out  ADDR_W  write address, port 1
- wdata1  out  DATA_W  write data, port 1
- we2  out  1  write enable, register file port 2
- waddr2  out  ADDR_W  write address, port 2
- wdata2  out  DATA_W  write data, port 2
- busy  out  2**ADDR_W  bit r = a write to register r is pending or staged

Behaviour:
- Reset (asynchronous, rst_n low):
  - we1, we2, waddr1/2, wdata1/2 and rr_ptr all clear to 0.
  - req_ready is 0 while reset is asserted.
  - Any staged write is discarded; reset mid-operation loses staged writes.
  - busy then reflects only req_valid.
- Handshake:
  - Requester i holds valid, addr and data stable until it sees req_ready[i]=1.
  - A transfer occurs when valid && ready are both high at a rising edge.
  - req_ready is combinational from req_valid, req_addr, rr_ptr and hold. It never asserts without valid.
- Arbitration (combinational, each cycle):
  - Scan requesters starting at rr_ptr, ascending, wrapping mod NUM_REQ.
  - The first valid requester is the port-1 grant (g1).
  - The next valid requester whose addr differs from g1's addr is the port-2 grant (g2). Requesters targeting the same address as g1 are skipped.
  - hold=1 means no grants.
- Round-robin pointer:
  - At least one grant: rr_ptr <= (index of last grant + 1) mod NUM_REQ.
  - No grant: rr_ptr is unchanged.
  - rr_ptr is a register of width clog2(NUM_REQ).
- Staging:
  - On the accept edge E, the g1 data/addr load into the port-1 output registers; the g2 data/addr load into the port-2 output registers.
  - we1/we2 are 1 during the cycle after E. The register file writes at edge E+1.
  - Total latency from accept to architectural update: 1 cycle. Read data is visible after E+1.
  - If there is no grant, we is 0 next cycle. Address and data outputs are don't-care when we is 0, and hold their last value.
  - we2 implies we1 and waddr1 != waddr2, so the file's internal port priority is never exercised.
- Busy:
  - busy[r] = OR over i of (req_valid[i] && req_addr[i]==r), OR (we1 && waddr1==r), OR (we2 && waddr2==r).
  - busy is combinational.
- Ordering and fairness:
  - Each requester's own writes complete in its own order.
  - Across requesters there is no ordering guarantee except that same-address writes are serialised by grant order.
  - A continuously valid requester is granted within NUM_REQ cycles when hold=0.
- Width rules:
  - Index arithmetic is unsigned, with wrap-around mod NUM_REQ.
  - Unused high bits when NUM_REQ is not a power of two are handled with an explicit compare, not truncation.

Decomposition:
- Package vcpu32_gr_pkg:
  - GR_ADDR_W=4, GR_DATA_W=32 and GR_NUM=16 constants.
  - typedef gr_wr_t {we, addr, data}, used for the staged ports.
- One sub-module, rr_dual_picker:
  - Combinational; takes valid, addr and rr_ptr; returns g1/g2 one-hot masks plus the last-grant index.
  - Verified standalone.

Test Plan:
1. Reset:
   - Stimulus: rst_n low mid-stream while we1=1.
   - Response: we1/we2 drop to 0 immediately; rr_ptr=0; busy=0 with no valid requests.
2. Single requester:
   - Stimulus: req0 writes addr 5, data 0xDEADBEEF.
   - Response: req_ready[0]=1 in the same cycle; next cycle we1=1, waddr1=5, wdata1=0xDEADBEEF, we2=0; busy[5] stays 1 through that cycle.
3. Dual grant:
   - Stimulus: req1 writes addr 3 (0x11), req2 writes addr 7 (0x22), rr_ptr=0.
   - Response: both ready; next cycle port1={3,0x11}, port2={7,0x22}; rr_ptr becomes 3.
4. Same-address conflict:
   - Stimulus: req0 and req1 both target addr 9.
   - Response: only req0 is granted (port1). req1 is granted in the following cycle, so its write lands one cycle later and the final value is req1's data.
5. Fairness:
   - Stimulus: all 4 requesters valid continuously, distinct addresses.
   - Response: grant pairs are (0,1), (2,3), (0,1) and so on; no requester waits more than 2 cycles.
6. Hold:
   - Stimulus: hold=1 for 3 cycles with req3 valid.
   - Response: req_ready=0 and we1=0 for those cycles; rr_ptr is unchanged; req3 is granted on the first cycle with hold=0.

Source files
------------

// File: rtl/vcpu32_gr_pkg.sv
// Shared definitions for the vcpu32 general register file and its writeback path.
//   GR_ADDR_W / GR_DATA_W / GR_NUM : register file geometry (16 x 32)
//   gr_wr_t                        : one staged write-port transaction
package vcpu32_gr_pkg;

    localparam int unsigned GR_ADDR_W = 4;
    localparam int unsigned GR_DATA_W = 32;
    localparam int unsigned GR_NUM    = 16;

    typedef struct packed {
        logic                 we;
        logic [GR_ADDR_W-1:0] addr;
        logic [GR_DATA_W-1:0] data;
    } gr_wr_t;

endpackage

// File: rtl/gr_writeback_scheduler_if.sv
// Writeback bus between the requesters, the scheduler and the register file.
//   req_valid/req_addr/req_data/hold : requester side, into the scheduler
//   req_ready                        : per-requester accept, out of the scheduler
//   we1/waddr1/wdata1, we2/...       : register file write ports 1 and 2
//   busy                             : per-register pending-write vector for issue interlock
// Modports: master = requesters + file + issue side (testbench), slave = scheduler.
interface gr_writeback_scheduler_if import vcpu32_gr_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = GR_ADDR_W,
    parameter int unsigned DATA_W  = GR_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      hold;
    logic                      we1;
    logic [ADDR_W-1:0]         waddr1;
    logic [DATA_W-1:0]         wdata1;
    logic                      we2;
    logic [ADDR_W-1:0]         waddr2;
    logic [DATA_W-1:0]         wdata2;
    logic [2**ADDR_W-1:0]      busy;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, we1, waddr1, wdata1, we2, waddr2, wdata2, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, we1, waddr1, wdata1, we2, waddr2, wdata2, busy
    );

endinterface

// File: rtl/rr_dual_picker.sv
// Combinational round-robin picker granting up to two requesters per cycle.
//   valid_i    : per-requester request
//   addr_i     : packed target addresses, requester i in slice i
//   rr_ptr_i   : first requester to consider
//   g1_o       : one-hot first grant (port 1)
//   g2_o       : one-hot second grant (port 2), never same address as g1
//   last_idx_o : index of the last grant made (g2 if present, else g1)
module rr_dual_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [PTR_W-1:0]          rr_ptr_i,
    output logic [NUM_REQ-1:0]        g1_o,
    output logic [NUM_REQ-1:0]        g2_o,
    output logic [PTR_W-1:0]          last_idx_o
);

    localparam int unsigned IDX_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] NumReqW = IDX_W'(NUM_REQ);

    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  sel;
    logic [ADDR_W-1:0] addr1;
    logic              found1;
    logic              found2;

    always_comb begin
        g1_o       = '0;
        g2_o       = '0;
        last_idx_o = '0;
        idx        = '0;
        sel        = '0;
        addr1      = '0;
        found1     = 1'b0;
        found2     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap compare so non power-of-two NUM_REQ never indexes past the end.
            idx = {1'b0, rr_ptr_i} + IDX_W'(k);
            if (idx >= NumReqW) begin
                idx = idx - NumReqW;
            end
            sel = idx[PTR_W-1:0];
            if (valid_i[sel]) begin
                if (!found1) begin
                    g1_o[sel]  = 1'b1;
                    found1     = 1'b1;
                    addr1      = addr_i[sel*ADDR_W +: ADDR_W];
                    last_idx_o = sel;
                end else if (!found2 && (addr_i[sel*ADDR_W +: ADDR_W] != addr1)) begin
                    // Same-address requesters are skipped so the file never sees a port clash.
                    g2_o[sel]  = 1'b1;
                    found2     = 1'b1;
                    last_idx_o = sel;
                end
            end
        end
    end

endmodule

// File: rtl/gr_writeback_scheduler.sv
// Writeback scheduler: shares the two register file write ports among NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of gr_writeback_scheduler_if (requests in, ready/write ports/busy out)
// Grants (up to two per cycle, round-robin, distinct addresses) are registered once and then
// presented on write ports 1/2 for one cycle.
module gr_writeback_scheduler import vcpu32_gr_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = GR_ADDR_W,
    parameter int unsigned DATA_W  = GR_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gr_writeback_scheduler_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   valid_eff;
    logic [NUM_REQ-1:0]   g1, g2;
    logic [PTR_W-1:0]     last_idx;
    logic [2**ADDR_W-1:0] busy_c;

    // Staged ports use the file's native layout; ADDR_W/DATA_W are expected to match it.
    gr_wr_t port1_q, port1_d;
    gr_wr_t port2_q, port2_d;

    assign valid_eff = bus.req_valid & {NUM_REQ{~bus.hold}};

    rr_dual_picker #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) u_picker (
        .valid_i    (valid_eff),
        .addr_i     (bus.req_addr),
        .rr_ptr_i   (rr_ptr_q),
        .g1_o       (g1),
        .g2_o       (g2),
        .last_idx_o (last_idx)
    );

    // Ready is masked during reset so nothing is accepted into flops being held clear.
    assign bus.req_ready = (g1 | g2) & {NUM_REQ{rst_n}};

    always_comb begin
        port1_d    = port1_q;
        port1_d.we = 1'b0;
        port2_d    = port2_q;
        port2_d.we = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g1[i]) begin
                port1_d.we   = 1'b1;
                port1_d.addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                port1_d.data = bus.req_data[i*DATA_W +: DATA_W];
            end
            if (g2[i]) begin
                port2_d.we   = 1'b1;
                port2_d.addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                port2_d.data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        if (|g1) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port1_q  <= '0;
            port2_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            port1_q  <= port1_d;
            port2_q  <= port2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.we1    = port1_q.we;
    assign bus.waddr1 = port1_q.addr;
    assign bus.wdata1 = port1_q.data;
    assign bus.we2    = port2_q.we;
    assign bus.waddr2 = port2_q.addr;
    assign bus.wdata2 = port2_q.data;

    // A register stays busy from request until its staged write has been presented.
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                busy_c[bus.req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (port1_q.we) begin
            busy_c[port1_q.addr] = 1'b1;
        end
        if (port2_q.we) begin
            busy_c[port2_q.addr] = 1'b1;
        end
    end

    assign bus.busy = busy_c;

endmodule

// File: tb/tb_gr_writeback_scheduler.sv
// Directed self-checking bench for gr_writeback_scheduler (NUM_REQ=4, 16x32 file).
module tb_gr_writeback_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [DW-1:0] rf [16];

    gr_writeback_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    gr_writeback_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: port 2 written after port 1 (never same address by design).
    initial begin
        for (int r = 0; r < 16; r++) rf[r] = '0;
    end
    always @(posedge clk) begin
        if (bus.we1) rf[bus.waddr1] <= bus.wdata1;
        if (bus.we2) rf[bus.waddr2] <= bus.wdata2;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        set_req(0, 1'b1, 4'd6, 32'h0000_0001);
        cycle();
        tests_run++;
        if (bus.we1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_we1: got %b expected %b", bus.we1, 1'b1);
        end
        set_req(0, 1'b0, 4'd0, 32'h0);
        set_req(1, 1'b1, 4'd2, 32'h0000_0002);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.we1 !== 1'b0 || bus.we2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_we: got we1=%b we2=%b expected 0 0", bus.we1, bus.we2);
        end
        tests_run++;
        if (dut.rr_ptr_q !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_ptr: got %0d expected %0d", dut.rr_ptr_q, 0);
        end
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected %b", bus.req_ready, 4'b0000);
        end
        tests_run++;
        if (bus.busy !== 16'h0004) begin
            tests_failed++;
            $display("FAIL reset_busy_valid: got %h expected %h", bus.busy, 16'h0004);
        end
        set_req(1, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.busy !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_busy_idle: got %h expected %h", bus.busy, 16'h0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        set_req(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected %b", bus.req_ready, 4'b0001);
        end
        cycle();
        set_req(0, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.we1 !== 1'b1 || bus.waddr1 !== 4'd5 || bus.wdata1 !== 32'hDEAD_BEEF
            || bus.we2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_port: got we1=%b a=%0d d=%h we2=%b expected 1 5 deadbeef 0",
                     bus.we1, bus.waddr1, bus.wdata1, bus.we2);
        end
        tests_run++;
        if (bus.busy !== 16'h0020) begin
            tests_failed++;
            $display("FAIL single_busy: got %h expected %h", bus.busy, 16'h0020);
        end
        cycle();
        tests_run++;
        if (bus.we1 !== 1'b0 || bus.busy !== 16'h0000 || rf[5] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_done: got we1=%b busy=%h rf5=%h expected 0 0000 deadbeef",
                     bus.we1, bus.busy, rf[5]);
        end
    endtask

    task automatic test_dual();
        apply_reset();
        set_req(1, 1'b1, 4'd3, 32'h11);
        set_req(2, 1'b1, 4'd7, 32'h22);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0110) begin
            tests_failed++;
            $display("FAIL dual_ready: got %b expected %b", bus.req_ready, 4'b0110);
        end
        cycle();
        set_req(1, 1'b0, 4'd0, 32'h0);
        set_req(2, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.we1 !== 1'b1 || bus.waddr1 !== 4'd3 || bus.wdata1 !== 32'h11) begin
            tests_failed++;
            $display("FAIL dual_port1: got we=%b a=%0d d=%h expected 1 3 11",
                     bus.we1, bus.waddr1, bus.wdata1);
        end
        tests_run++;
        if (bus.we2 !== 1'b1 || bus.waddr2 !== 4'd7 || bus.wdata2 !== 32'h22) begin
            tests_failed++;
            $display("FAIL dual_port2: got we=%b a=%0d d=%h expected 1 7 22",
                     bus.we2, bus.waddr2, bus.wdata2);
        end
        tests_run++;
        if (dut.rr_ptr_q !== 2'd3) begin
            tests_failed++;
            $display("FAIL dual_ptr: got %0d expected %0d", dut.rr_ptr_q, 3);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        set_req(0, 1'b1, 4'd9, 32'hA0);
        set_req(1, 1'b1, 4'd9, 32'hB1);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL conflict_ready0: got %b expected %b", bus.req_ready, 4'b0001);
        end
        cycle();
        set_req(0, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.we1 !== 1'b1 || bus.waddr1 !== 4'd9 || bus.wdata1 !== 32'hA0
            || bus.we2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_first: got we1=%b a=%0d d=%h we2=%b expected 1 9 a0 0",
                     bus.we1, bus.waddr1, bus.wdata1, bus.we2);
        end
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL conflict_ready1: got %b expected %b", bus.req_ready, 4'b0010);
        end
        cycle();
        set_req(1, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.we1 !== 1'b1 || bus.waddr1 !== 4'd9 || bus.wdata1 !== 32'hB1) begin
            tests_failed++;
            $display("FAIL conflict_second: got we1=%b a=%0d d=%h expected 1 9 b1",
                     bus.we1, bus.waddr1, bus.wdata1);
        end
        cycle();
        tests_run++;
        if (rf[9] !== 32'hB1) begin
            tests_failed++;
            $display("FAIL conflict_final: got %h expected %h", rf[9], 32'hB1);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_ready [4];
        logic [AW-1:0] exp_a1 [4];
        logic [AW-1:0] exp_a2 [4];
        exp_ready = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        exp_a1    = '{4'd1, 4'd3, 4'd1, 4'd3};
        exp_a2    = '{4'd2, 4'd4, 4'd2, 4'd4};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (bus.req_ready !== exp_ready[k]) begin
                tests_failed++;
                $display("FAIL fair_ready[%0d]: got %b expected %b", k, bus.req_ready,
                         exp_ready[k]);
            end
            cycle();
            tests_run++;
            if (bus.we1 !== 1'b1 || bus.we2 !== 1'b1 || bus.waddr1 !== exp_a1[k]
                || bus.waddr2 !== exp_a2[k]) begin
                tests_failed++;
                $display("FAIL fair_ports[%0d]: got we=%b%b a1=%0d a2=%0d expected 11 %0d %0d",
                         k, bus.we1, bus.we2, bus.waddr1, bus.waddr2, exp_a1[k], exp_a2[k]);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_hold();
        apply_reset();
        set_req(0, 1'b1, 4'd0, 32'h5);
        cycle();
        set_req(0, 1'b0, 4'd0, 32'h0);
        bus.hold = 1'b1;
        set_req(3, 1'b1, 4'hC, 32'h33);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (bus.req_ready !== 4'b0000 || dut.rr_ptr_q !== 2'd1) begin
                tests_failed++;
                $display("FAIL hold_ready[%0d]: got ready=%b ptr=%0d expected 0000 1", k,
                         bus.req_ready, dut.rr_ptr_q);
            end
            cycle();
            tests_run++;
            if (bus.we1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_we1[%0d]: got %b expected %b", k, bus.we1, 1'b0);
            end
        end
        bus.hold = 1'b0;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL hold_release_ready: got %b expected %b", bus.req_ready, 4'b1000);
        end
        cycle();
        set_req(3, 1'b0, 4'd0, 32'h0);
        #1;
        tests_run++;
        if (bus.we1 !== 1'b1 || bus.waddr1 !== 4'hC || bus.wdata1 !== 32'h33
            || dut.rr_ptr_q !== 2'd0) begin
            tests_failed++;
            $display("FAIL hold_release_port: got we1=%b a=%0d d=%h ptr=%0d expected 1 12 33 0",
                     bus.we1, bus.waddr1, bus.wdata1, dut.rr_ptr_q);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
        test_reset();
        test_single();
        test_dual();
        test_conflict();
        test_fairness();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
